// File: rtl/uart_tx_ctrl_pkg.sv
// Shared definitions for the UART transmit frame controller: FSM states,
// line mux select codes and the fixed line levels.
package uart_tx_ctrl_pkg;

    localparam int   DATA_WIDTH  = 8;
    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    typedef enum logic [2:0] {
        SEL_IDLE  = 3'd0,
        SEL_START = 3'd1,
        SEL_SER   = 3'd2,
        SEL_PAR   = 3'd3,
        SEL_STOP  = 3'd4
    } tx_sel_t;

    // Line source for each frame state; unused encodings park the line high.
    function automatic tx_sel_t state_sel(input tx_state_t s);
        case (s)
            ST_START:  return SEL_START;
            ST_DATA:   return SEL_SER;
            ST_PARITY: return SEL_PAR;
            ST_STOP:   return SEL_STOP;
            default:   return SEL_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/uart_tx_ctrl_parity_calc.sv
// Combinational parity generator, shared between the TX and RX paths.
// par_typ = 0 gives even parity, 1 gives odd parity.
module parity_calc #(
    parameter int W = 8
) (
    input  logic [W-1:0] data,
    input  logic         par_typ,
    output logic         par_bit
);

    assign par_bit = (^data) ^ par_typ;

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller: start bit, 8 data bits through the external
// serializer, optional parity, STOP_BITS stop bits. CLK runs at the bit rate.
module uart_tx_ctrl
    import uart_tx_ctrl_pkg::*;
#(
    parameter int STOP_BITS = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  ser_done,
    input  logic                  ser_data,
    output logic                  ser_en,
    output logic [DATA_WIDTH-1:0] ser_pdata,
    output logic                  TX_OUT,
    output logic                  Busy
);

    tx_state_t             state, next_state;
    logic [DATA_WIDTH-1:0] data_reg;
    logic                  par_en_r, par_typ_r;
    logic [1:0]            stop_cnt;
    logic                  last_stop, accept, par_bit;

    assign last_stop = (stop_cnt == 2'(STOP_BITS - 1));
    assign accept    = DATA_VALID && ((state == ST_IDLE) || ((state == ST_STOP) && last_stop));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= ST_IDLE;
            data_reg  <= '0;
            par_en_r  <= 1'b0;
            par_typ_r <= 1'b0;
            stop_cnt  <= '0;
        end else begin
            state <= next_state;
            if (accept) begin
                data_reg  <= P_DATA;
                par_en_r  <= PAR_EN;
                par_typ_r <= PAR_TYP;
            end
            // stop_cnt is only meaningful in STOP; it is zero on entry.
            if ((state == ST_STOP) && !last_stop) stop_cnt <= stop_cnt + 2'd1;
            else                                  stop_cnt <= '0;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (accept) next_state = ST_START;
            ST_START:  next_state = ST_DATA;
            ST_DATA:   if (ser_done) next_state = par_en_r ? ST_PARITY : ST_STOP;
            ST_PARITY: next_state = ST_STOP;
            ST_STOP: begin
                if (accept)         next_state = ST_START;
                else if (last_stop) next_state = ST_IDLE;
            end
            default:   next_state = ST_IDLE;
        endcase
    end

    parity_calc #(.W(DATA_WIDTH)) u_parity (
        .data    (data_reg),
        .par_typ (par_typ_r),
        .par_bit (par_bit)
    );

    always_comb begin
        TX_OUT = IDLE_LEVEL;
        case (state_sel(state))
            SEL_START: TX_OUT = START_LEVEL;
            SEL_SER:   TX_OUT = ser_data;
            SEL_PAR:   TX_OUT = par_bit;
            SEL_STOP:  TX_OUT = STOP_LEVEL;
            default:   TX_OUT = IDLE_LEVEL;
        endcase
    end

    // ser_done gates the enable so the serializer never shifts past bit 7.
    assign ser_en    = (state == ST_START) || ((state == ST_DATA) && !ser_done);
    assign ser_pdata = data_reg;
    assign Busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: two instances (1 and 2 stop bits), each with a
// behavioural serializer, checked against a frame-level reference model.
module tb_uart_tx_ctrl;

    logic            CLK = 1'b0;
    logic            RST;
    logic [7:0]      pd;
    logic            pe, pt;
    logic [1:0]      dv, ser_done, ser_data, ser_en, tx, busy;
    logic [1:0][7:0] ser_pdata;

    int checks   = 0;
    int failures = 0;

    // Reference model: a frame is a list of expected line bits and ser_en values.
    bit         m_act [2];
    int         m_pos [2];
    int         m_len [2];
    bit [15:0]  m_bits[2];
    bit [15:0]  m_ens [2];
    logic [7:0] m_byte[2];

    bit tv_a5 [12] = '{0,1,0,1,0,0,1,0,1,1,1,1};

    always #5 CLK = ~CLK;

    for (genvar g = 0; g < 2; g++) begin : g_inst
        logic [3:0] scnt;
        logic       sdat;

        // Serializer partner: load bit0 on the first enable, present bits 0..7,
        // flag done while bit 7 is on the line, then clear.
        always_ff @(posedge CLK or negedge RST) begin
            if (!RST) begin
                scnt <= '0;
                sdat <= 1'b0;
            end else if (scnt == 4'd8) begin
                scnt <= '0;
            end else if (ser_en[g]) begin
                sdat <= ser_pdata[g][scnt[2:0]];
                scnt <= scnt + 4'd1;
            end
        end
        assign ser_done[g] = (scnt == 4'd8);
        assign ser_data[g] = sdat;

        uart_tx_ctrl #(.STOP_BITS(g + 1)) u_dut (
            .CLK        (CLK),
            .RST        (RST),
            .P_DATA     (pd),
            .DATA_VALID (dv[g]),
            .PAR_EN     (pe),
            .PAR_TYP    (pt),
            .ser_done   (ser_done[g]),
            .ser_data   (ser_data[g]),
            .ser_en     (ser_en[g]),
            .ser_pdata  (ser_pdata[g]),
            .TX_OUT     (tx[g]),
            .Busy       (busy[g])
        );
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int g = 0; g < 2; g++) begin
            m_act[g]  = 0;
            m_pos[g]  = 0;
            m_len[g]  = 0;
            m_byte[g] = 8'h00;
        end
    endtask

    task automatic model_edge();
        for (int g = 0; g < 2; g++) begin
            if (dv[g] && (!m_act[g] || m_pos[g] == m_len[g] - 1)) begin
                int n;
                m_bits[g] = '0;
                m_ens[g]  = '0;
                m_bits[g][0] = 1'b0;
                m_ens[g][0]  = 1'b1;
                for (int i = 0; i < 8; i++) begin
                    m_bits[g][1 + i] = pd[i];
                    m_ens[g][1 + i]  = (i < 7);
                end
                n = 9;
                if (pe) begin
                    m_bits[g][n] = 1'(($countones(pd) % 2) ^ int'(pt));
                    n++;
                end
                for (int s = 0; s <= g; s++) begin
                    m_bits[g][n] = 1'b1;
                    n++;
                end
                m_len[g]  = n;
                m_pos[g]  = 0;
                m_act[g]  = 1;
                m_byte[g] = pd;
            end else if (m_act[g]) begin
                m_pos[g]++;
                if (m_pos[g] == m_len[g]) m_act[g] = 0;
            end
        end
    endtask

    task automatic check_all();
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("tx%0d", g),    8'(tx[g]),     m_act[g] ? 8'(m_bits[g][m_pos[g]]) : 8'h1);
            chk($sformatf("busy%0d", g),  8'(busy[g]),   8'(m_act[g]));
            chk($sformatf("ser_en%0d", g), 8'(ser_en[g]), m_act[g] ? 8'(m_ens[g][m_pos[g]]) : 8'h0);
            chk($sformatf("pdata%0d", g), ser_pdata[g],  m_byte[g]);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        if (RST) model_edge();
        @(negedge CLK);
        check_all();
    endtask

    initial begin
        RST = 1'b0;
        dv  = 2'b00;
        pd  = 8'h00;
        pe  = 1'b0;
        pt  = 1'b0;
        model_reset();
        #2;
        check_all();
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        step();

        // 0xA5, no parity: explicit line sequence
        pd = 8'hA5; pe = 0; dv[0] = 1;
        for (int i = 0; i < 12; i++) begin
            step();
            dv[0] = 0;
            chk("a5_line", 8'(tx[0]), 8'(tv_a5[i]));
            chk("a5_busy", 8'(busy[0]), (i < 10) ? 8'h1 : 8'h0);
        end

        // 0x03 even then odd parity, 11-cycle frames
        for (int t = 0; t < 2; t++) begin
            pd = 8'h03; pe = 1; pt = 1'(t); dv[0] = 1;
            for (int i = 1; i <= 12; i++) begin
                step();
                dv[0] = 0;
                if (i == 10) chk("par03", 8'(tx[0]), 8'(t));
                if (i == 11) chk("par03_stop_busy", 8'(busy[0]), 8'h1);
                if (i == 12) chk("par03_idle", 8'(busy[0]), 8'h0);
            end
        end

        // Back-to-back: DATA_VALID held, 0x55 then 0xAA
        pd = 8'h55; pe = 0; dv[0] = 1;
        step();
        pd = 8'hAA;
        for (int i = 2; i <= 20; i++) begin
            step();
            if (i == 11) chk("b2b_start", 8'(tx[0]), 8'h0);
            if (i >= 11) dv[0] = 0;
            chk("b2b_busy", 8'(busy[0]), 8'h1);
        end
        repeat (2) step();

        // DATA_VALID pulsed mid-frame with a new byte is ignored
        pd = 8'hA5; dv[0] = 1;
        step();
        dv[0] = 0;
        repeat (3) step();
        pd = 8'h00; dv[0] = 1;
        step();
        dv[0] = 0;
        for (int i = 6; i <= 12; i++) begin
            step();
            if (i == 8) chk("ignore_bit6", 8'(tx[0]), 8'h0);
            if (i == 9) chk("ignore_bit7", 8'(tx[0]), 8'h1);
        end
        chk("ignore_byte", ser_pdata[0], 8'hA5);

        // Reset in DATA cycle 4 aborts immediately
        pd = 8'hA5; dv[0] = 1;
        step();
        dv[0] = 0;
        repeat (4) step();
        #2 RST = 1'b0;
        #1;
        model_reset();
        chk("rst_tx", 8'(tx[0]), 8'h1);
        chk("rst_busy", 8'(busy[0]), 8'h0);
        chk("rst_ser_en", 8'(ser_en[0]), 8'h0);
        @(negedge CLK);
        RST = 1'b1;
        pd = 8'h3C; pe = 1; pt = 0; dv[0] = 1;
        step();
        dv[0] = 0;
        repeat (12) step();

        // Two stop bits, 0xFF with odd parity: 12-cycle frame
        pd = 8'hFF; pe = 1; pt = 1; dv[1] = 1;
        for (int i = 1; i <= 13; i++) begin
            step();
            dv[1] = 0;
            if (i == 10) chk("ff_par", 8'(tx[1]), 8'h1);
            if (i == 12) chk("ff_stop2_busy", 8'(busy[1]), 8'h1);
            if (i == 13) chk("ff_idle", 8'(busy[1]), 8'h0);
        end

        // Randomized traffic on both instances
        for (int i = 0; i < 600; i++) begin
            dv[0] = ($urandom_range(0, 3) == 0);
            dv[1] = ($urandom_range(0, 2) == 0);
            pd    = 8'($urandom);
            pe    = 1'($urandom);
            pt    = 1'($urandom);
            step();
        end
        dv = 2'b00;
        repeat (16) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
